// File: rtl/register_bank.sv
// General-purpose/address register bank: 2**SelW registers of NBits, a shared
// function select applied to every register enabled by regsel, sticky wrap flags.
module register_bank #(
  parameter int NBits = 16,
  parameter int SelW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            funsel,
  input  logic [(1<<SelW)-1:0]  regsel,
  input  logic [NBits-1:0]      i,
  input  logic                  wrap_clr,
  input  logic [SelW-1:0]       osel_a,
  input  logic [SelW-1:0]       osel_b,
  output logic [NBits-1:0]      oa,
  output logic [NBits-1:0]      ob,
  output logic                  zero_a,
  output logic [(1<<SelW)-1:0]  wrap
);

  localparam int NRegs = 1 << SelW;
  localparam int Half  = NBits / 2;

  typedef enum logic [2:0] {
    FN_CLR  = 3'b000,
    FN_LOAD = 3'b001,
    FN_DEC  = 3'b010,
    FN_INC  = 3'b011,
    FN_LDLO = 3'b100,
    FN_LDHI = 3'b101,
    FN_SHL  = 3'b110,
    FN_SHR  = 3'b111
  } fun_e;

  logic [NBits-1:0] r_regs [NRegs];
  logic [NRegs-1:0] r_wrap;

  logic [NBits-1:0] w_next [NRegs];
  logic [NRegs-1:0] w_wrap_ev;
  logic [NRegs-1:0] w_full_wr;
  logic [NRegs-1:0] w_wrap_next;
  fun_e             w_fun;

  assign w_fun = fun_e'(funsel);

  // Each enabled register computes only from its own current value.
  always_comb begin
    for (int k = 0; k < NRegs; k++) begin
      w_next[k]    = r_regs[k];
      w_wrap_ev[k] = 1'b0;
      w_full_wr[k] = 1'b0;
      if (regsel[k]) begin
        unique case (w_fun)
          FN_CLR: begin
            w_next[k]    = '0;
            w_full_wr[k] = 1'b1;
          end
          FN_LOAD: begin
            w_next[k]    = i;
            w_full_wr[k] = 1'b1;
          end
          FN_DEC: begin
            w_next[k]    = r_regs[k] - NBits'(1);
            w_wrap_ev[k] = (r_regs[k] == '0);
          end
          FN_INC: begin
            w_next[k]    = r_regs[k] + NBits'(1);
            w_wrap_ev[k] = (r_regs[k] == '1);
          end
          FN_LDLO: w_next[k] = {r_regs[k][NBits-1:Half], i[Half-1:0]};
          FN_LDHI: w_next[k] = {i[Half-1:0], r_regs[k][Half-1:0]};
          FN_SHL:  w_next[k] = {r_regs[k][NBits-2:0], 1'b0};
          FN_SHR:  w_next[k] = {1'b0, r_regs[k][NBits-1:1]};
          default: w_next[k] = r_regs[k];
        endcase
      end
    end
  end

  // A wrap event outranks every clearing source in the same cycle.
  always_comb begin
    for (int k = 0; k < NRegs; k++) begin
      if (w_wrap_ev[k])
        w_wrap_next[k] = 1'b1;
      else if (w_full_wr[k] || wrap_clr)
        w_wrap_next[k] = 1'b0;
      else
        w_wrap_next[k] = r_wrap[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NRegs; k++) r_regs[k] <= '0;
      r_wrap <= '0;
    end else begin
      for (int k = 0; k < NRegs; k++) r_regs[k] <= w_next[k];
      r_wrap <= w_wrap_next;
    end
  end

  // Read ports show stored values only; a write becomes visible after its edge.
  assign oa     = r_regs[osel_a];
  assign ob     = r_regs[osel_b];
  assign zero_a = (oa == '0);
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed scenarios plus random traffic, with a
// queue-based scoreboard fed by an arithmetic reference model.
module tb_register_bank;

  localparam int  NB = 16;
  localparam int  NR = 4;
  localparam int  H  = 256;
  localparam longint M = 65536;
  localparam int  W  = 2 * NB + 1 + NR;

  logic            clk;
  logic            rst_n;
  logic [2:0]      funsel;
  logic [NR-1:0]   regsel;
  logic [NB-1:0]   i;
  logic            wrap_clr;
  logic [1:0]      osel_a;
  logic [1:0]      osel_b;
  logic [NB-1:0]   oa;
  logic [NB-1:0]   ob;
  logic            zero_a;
  logic [NR-1:0]   wrap;

  register_bank #(.NBits(NB), .SelW(2)) dut (
    .clk(clk), .rst_n(rst_n), .funsel(funsel), .regsel(regsel), .i(i),
    .wrap_clr(wrap_clr), .osel_a(osel_a), .osel_b(osel_b),
    .oa(oa), .ob(ob), .zero_a(zero_a), .wrap(wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard state
  longint        m_reg [NR];
  bit            m_wrap [NR];
  logic [W-1:0]  exp_q [$];
  int            n_pass = 0;
  int            n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NR; k++) begin
      m_reg[k]  = 0;
      m_wrap[k] = 0;
    end
  endfunction

  function automatic void model_step(input logic [2:0] f, input logic [NR-1:0] rs,
                                     input logic [NB-1:0] iv, input logic wc);
    longint d, nd, lo;
    bit nw;
    lo = longint'(iv) % H;
    for (int k = 0; k < NR; k++) begin
      d  = m_reg[k];
      nd = d;
      nw = wc ? 1'b0 : m_wrap[k];
      if (rs[k]) begin
        case (f)
          3'd0: begin nd = 0; nw = 0; end
          3'd1: begin nd = longint'(iv); nw = 0; end
          3'd2: if (d == 0) begin nd = M - 1; nw = 1; end else nd = d - 1;
          3'd3: if (d == M - 1) begin nd = 0; nw = 1; end else nd = d + 1;
          3'd4: nd = (d / H) * H + lo;
          3'd5: nd = lo * H + d % H;
          3'd6: nd = (d * 2) % M;
          default: nd = d / 2;
        endcase
      end
      m_reg[k]  = nd;
      m_wrap[k] = nw;
    end
  endfunction

  function automatic logic [NR-1:0] model_wrap_vec();
    logic [NR-1:0] v;
    for (int k = 0; k < NR; k++) v[k] = m_wrap[k];
    return v;
  endfunction

  function automatic logic [W-1:0] model_expect(input logic [1:0] sa, input logic [1:0] sb);
    logic [NB-1:0] ea, eb;
    ea = NB'(m_reg[sa]);
    eb = NB'(m_reg[sb]);
    return {ea, eb, (m_reg[sa] == 0), model_wrap_vec()};
  endfunction

  // driver: inputs change just after a falling edge; expected response is
  // queued once the model has taken the same rising edge.
  task automatic drive(input logic [2:0] f, input logic [NR-1:0] rs, input logic [NB-1:0] iv,
                       input logic wc, input logic [1:0] sa, input logic [1:0] sb);
    funsel = f; regsel = rs; i = iv; wrap_clr = wc; osel_a = sa; osel_b = sb;
    #1 check("pre_edge_oa", 32'(oa), 32'(m_reg[sa]));
    @(posedge clk);
    model_step(f, rs, iv, wc);
    exp_q.push_back(model_expect(sa, sb));
    @(negedge clk);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("oa", 32'(oa), 32'(e[W-1 -: NB]));
      check("ob", 32'(ob), 32'(e[W-NB-1 -: NB]));
      check("zero_a", 32'(zero_a), 32'(e[NR]));
      check("wrap", 32'(wrap), 32'(e[NR-1:0]));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oa"}, 32'(oa), 32'h0);
    check({tag, "_ob"}, 32'(ob), 32'h0);
    check({tag, "_zero_a"}, 32'(zero_a), 32'h1);
    check({tag, "_wrap"}, 32'(wrap), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; funsel = 3'd0; regsel = '0; i = '0; wrap_clr = 1'b0;
    osel_a = 2'd1; osel_b = 2'd3;
    model_reset();
    #3 check_reset_outputs("por");
    #9 rst_n = 1'b1;

    // wrap all via decrement of zero, then load three registers
    drive(3'd2, 4'b1111, 16'h0, 1'b0, 2'd0, 2'd1);
    check("dec_all_wrap", 32'(wrap), 32'hF);
    drive(3'd1, 4'b1110, 16'h1234, 1'b0, 2'd1, 2'd0);

    // asynchronous reset between edges, held across an edge with an update pending
    funsel = 3'd3; regsel = 4'b1111; osel_a = 2'd2; osel_b = 2'd3;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // load and read
    drive(3'd1, 4'b0100, 16'hBEEF, 1'b0, 2'd2, 2'd0);
    check("load_beef", 32'(oa), 32'hBEEF);

    // multi-register increment with wrap, then wrap_clr together with increment
    drive(3'd1, 4'b0010, 16'hFFFF, 1'b0, 2'd1, 2'd3);
    drive(3'd1, 4'b1000, 16'h0007, 1'b0, 2'd1, 2'd3);
    drive(3'd3, 4'b1010, 16'h0, 1'b0, 2'd1, 2'd3);
    check("inc_wrap_vec", 32'(wrap), 32'h2);
    check("inc_r3", 32'(ob), 32'h8);
    drive(3'd3, 4'b1010, 16'h0, 1'b1, 2'd1, 2'd3);
    check("inc_clr_vec", 32'(wrap), 32'h0);

    // decrement underflow beats wrap_clr
    drive(3'd0, 4'b0001, 16'h0, 1'b0, 2'd0, 2'd0);
    drive(3'd2, 4'b0001, 16'h0, 1'b1, 2'd0, 2'd1);
    check("dec_under_r0", 32'(oa), 32'hFFFF);
    check("dec_under_wrap0", 32'(wrap[0]), 32'h1);

    // half loads and shifts
    drive(3'd1, 4'b0100, 16'h00FF, 1'b0, 2'd2, 2'd2);
    drive(3'd5, 4'b0100, 16'h00AB, 1'b0, 2'd2, 2'd0);
    check("ldhi", 32'(oa), 32'hABFF);
    drive(3'd4, 4'b0100, 16'h0012, 1'b0, 2'd2, 2'd0);
    check("ldlo", 32'(oa), 32'hAB12);
    drive(3'd6, 4'b0100, 16'h0, 1'b0, 2'd2, 2'd0);
    check("shl", 32'(oa), 32'h5624);
    drive(3'd7, 4'b0100, 16'h0, 1'b0, 2'd2, 2'd0);
    check("shr", 32'(oa), 32'h2B12);
    check("half_wrap2", 32'(wrap[2]), 32'h0);

    // idle mask with every function code
    for (int f = 0; f < 8; f++)
      drive(3'(f), 4'b0000, 16'($urandom), 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // random traffic; bias toward wrap boundaries via all-ones / zero loads
    for (int n = 0; n < 400; n++) begin
      logic [NB-1:0] iv;
      logic [NR-1:0] rs;
      case ($urandom_range(0, 3))
        0: iv = 16'hFFFF;
        1: iv = 16'h0000;
        default: iv = 16'($urandom);
      endcase
      rs = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      drive(3'($urandom_range(0, 7)), rs, iv, ($urandom_range(0, 7) == 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    #1 check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised successor to the single function-select register: a bank of 2**SelW registers, each NBits wide.
- Clocked, with asynchronous active-low reset, a 3-bit function select and a per-register write-enable mask.
- Per-register sticky wrap flags, and two independent combinational read ports.
- Sits in the datapath as the general-purpose/address register bank feeding the ALU and memory address muxes.

Parameters:
- NBits, 16, register width; even, >= 4.
- SelW, 2, read-select width; bank holds NRegs = 2**SelW registers (localparam, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- funsel  input  3  operation applied to every enabled register.
- regsel  input  NRegs  write-enable mask; bit k enables register k.
- i  input  NBits  load data.
- wrap_clr  input  1  clears all sticky wrap flags.
- osel_a  input  SelW  read select, port A.
- osel_b  input  SelW  read select, port B.
- oa  output  NBits  contents of register osel_a.
- ob  output  NBits  contents of register osel_b.
- zero_a  output  1  high when oa == 0.
- wrap  output  NRegs  sticky wrap flag per register.

Behaviour:
- Reset:
  - rst_n low clears all registers and all wrap bits immediately, independent of clk.
  - A reset asserted mid-operation discards that cycle's update.
  - While rst_n is low: oa = ob = 0, zero_a = 1, wrap = 0.
  - First update occurs on the first rising clk edge with rst_n high.
- Update timing: on rising clk, for each k with regsel[k] = 1, register k (value d) becomes:
  - 000 clear: 0.
  - 001 load: i.
  - 010 decrement: d - 1, modulo 2**NBits.
  - 011 increment: d + 1, modulo 2**NBits.
  - 100 load low half: {d[NBits-1:NBits/2], i[NBits/2-1:0]}.
  - 101 load high half: {i[NBits/2-1:0], d[NBits/2-1:0]}; the low half of i goes into the high half.
  - 110 shift left logical: {d[NBits-2:0], 1'b0}.
  - 111 shift right logical: {1'b0, d[NBits-1:1]}.
- Mask rules:
  - regsel[k] = 0: register k holds its value.
  - regsel all zero: no state change except wrap_clr.
  - Multiple bits set: each enabled register computes from its own value (e.g. increment bumps each independently).
- Read ports:
  - oa/ob are purely combinational from stored values; no write-through bypass.
  - A register written at edge N appears on oa/ob after edge N.
  - osel_a == osel_b is legal; both ports show the same value.
- Wrap flags (register k):
  - Set: increment with d = all ones, or decrement with d = 0; set at the same edge as the wrapped result.
  - Cleared: by clear (000) or full load (001) on that register, or by wrap_clr = 1 (all bits).
  - Unaffected: half loads and shifts; shifted-out bits are discarded with no flag.
  - Priority: a wrap event in the same cycle as wrap_clr or clear/load wins, so the flag ends set. Clear/load with wrap_clr leaves it 0.
  - Otherwise the flag holds.
- No internal X propagation: funsel is fully decoded (all 8 codes defined).

Test Plan:
- Reset/async: with registers loaded with 16'h1234 and rst_n pulsed low between edges -> oa = ob = 0, wrap = 0, zero_a = 1 before the next clk edge.
- Load and read: regsel = 4'b0100, funsel = 001, i = 16'hBEEF, then osel_a = 2, osel_b = 0 -> oa = 16'hBEEF, ob = 0, zero_a = 0. oa is unchanged until after the edge.
- Multi-register increment with wrap:
  - R1 = 16'hFFFF, R3 = 16'h0007, regsel = 4'b1010, funsel = 011 -> R1 = 0, R3 = 16'h0008, wrap = 4'b0010.
  - Next edge with wrap_clr = 1, funsel = 011 -> R1 = 1, R3 = 9, wrap = 4'b0000.
- Decrement underflow with simultaneous clear: R0 = 0, funsel = 010, regsel = 4'b0001, wrap_clr = 1 -> R0 = 16'hFFFF, wrap[0] = 1 (event wins).
- Half loads and shifts on R2 = 16'h00FF:
  - funsel 101, i = 16'h00AB -> 16'hABFF.
  - Then 100, i = 16'h0012 -> 16'hAB12.
  - Then 110 -> 16'h5624.
  - Then 111 -> 16'h2B12.
  - wrap[2] stays 0 throughout.
- Idle mask: regsel = 0 with every funsel code over 8 cycles -> all registers and wrap unchanged.
